master: RTL and testbench

Single-byte I2C master controller. Accepts a 7-bit address, read/write flag and data byte from a command interface, and runs one complete I2C transaction on open-drain SCL/SDA: START, address+R/W, ACK, one data byte, ACK/NACK, STOP. An internal timing generator divides the system clock into four phases per SCL bit. The block sits between on-chip control logic and the external I2C memory bus.

---
 rtl/master_pkg.sv | 25 ++
 rtl/master_timing_gen.sv | 47 ++++
 rtl/master.sv | 192 +++++++++++++++++++
 tb/tb_master.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/master_pkg.sv
// Shared types and timing constants for the single-byte I2C master.
package master_pkg;

  localparam int SYS_FREQ_DEF = 50_000_000;
  localparam int I2C_FREQ_DEF = 100_000;

  function automatic int clk_count4(input int sys_freq, input int i2c_freq);
    return sys_freq / (4 * i2c_freq);
  endfunction

  localparam int CLK_COUNT4 = clk_count4(SYS_FREQ_DEF, I2C_FREQ_DEF);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    START       = 4'd1,
    ADDR        = 4'd2,
    ADDR_ACK    = 4'd3,
    WRITE_DATA  = 4'd4,
    READ_DATA   = 4'd5,
    DATA_ACK    = 4'd6,
    MASTER_NACK = 4'd7,
    STOP        = 4'd8
  } state_e;

endpackage

// File: rtl/master_timing_gen.sv
// Quarter-bit timing generator: a tick counter feeding a 2-bit phase counter.
module i2c_timing_gen
  import master_pkg::*;
#(
  parameter int COUNT4 = CLK_COUNT4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  output logic [1:0] phase_o,
  output logic       bit_end_o
);

  logic [6:0] tick_q, tick_d;
  logic [1:0] phase_q, phase_d;
  logic       tick_wrap;

  assign tick_wrap = (tick_q == 7'(COUNT4 - 1));

  always_comb begin
    tick_d  = tick_q;
    phase_d = phase_q;
    if (!enable_i) begin
      tick_d  = '0;
      phase_d = '0;
    end else if (tick_wrap) begin
      tick_d  = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      tick_d = tick_q + 7'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q  <= '0;
      phase_q <= '0;
    end else begin
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o   = phase_q;
  assign bit_end_o = enable_i && tick_wrap && (phase_q == 2'd3);

endmodule

// File: rtl/master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
module master
  import master_pkg::*;
#(
  parameter int SYS_FREQ = SYS_FREQ_DEF,
  parameter int I2C_FREQ = I2C_FREQ_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  input  logic       dataValid,
  input  logic [6:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       ackErr,
  output logic       done,
  inout  wire        sda,
  inout  wire        scl,
  output logic [3:0] state_o
);

  // Request: dataValid is taken only in IDLE; busy is high from acceptance until
  // the cycle done pulses, and requests raised while busy are dropped.
  state_e     state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] data_q, data_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ack_err_q, ack_err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] dout_q, dout_d;
  logic       smp_q, smp_d;
  logic [1:0] phase_prev_q;

  logic [1:0] phase;
  logic       bit_end;
  logic       sample_now;
  logic       bit_scl_low;
  logic       scl_low, sda_low;
  logic       sda_in;

  i2c_timing_gen #(
    .COUNT4(clk_count4(SYS_FREQ, I2C_FREQ))
  ) u_timing (
    .clk_i    (clk),
    .rst_ni   (rst),
    .enable_i (state_q != IDLE),
    .phase_o  (phase),
    .bit_end_o(bit_end)
  );

  assign sda_in      = sda;
  assign sample_now  = (phase == 2'd2) && (phase_prev_q == 2'd1);
  assign bit_scl_low = (phase == 2'd0) || (phase == 2'd3);

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    data_d    = data_q;
    rw_d      = rw_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dout_d    = dout_q;
    smp_d     = smp_q;
    scl_low   = 1'b0;
    sda_low   = 1'b0;

    if (sample_now) smp_d = sda_in;

    case (state_q)
      IDLE: begin
        if (dataValid) begin
          tx_d      = {addr, rw};
          data_d    = din;
          rw_d      = rw;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        sda_low = phase[1];
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR, WRITE_DATA: begin
        scl_low = bit_scl_low;
        sda_low = !tx_q[7];
        if (bit_end) begin
          tx_d  = {tx_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
        end
      end
      ADDR_ACK: begin
        scl_low = bit_scl_low;
        if (bit_end) begin
          if (smp_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (rw_q) begin
            state_d = READ_DATA;
          end else begin
            tx_d    = data_q;
            state_d = WRITE_DATA;
          end
        end
      end
      READ_DATA: begin
        scl_low = bit_scl_low;
        if (sample_now) rx_d = {rx_q[6:0], sda_in};
        if (bit_end) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            dout_d  = rx_q;
            state_d = MASTER_NACK;
          end
        end
      end
      DATA_ACK: begin
        scl_low = bit_scl_low;
        if (bit_end) begin
          if (smp_q) ack_err_d = 1'b1;
          state_d = STOP;
        end
      end
      MASTER_NACK: begin
        scl_low = bit_scl_low;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        scl_low = (phase == 2'd0);
        sda_low = !phase[1];
        if (bit_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      data_q       <= '0;
      rw_q         <= 1'b0;
      rx_q         <= '0;
      cnt_q        <= '0;
      ack_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      smp_q        <= 1'b0;
      phase_prev_q <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      data_q       <= data_d;
      rw_q         <= rw_d;
      rx_q         <= rx_d;
      cnt_q        <= cnt_d;
      ack_err_q    <= ack_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      smp_q        <= smp_d;
      phase_prev_q <= phase;
    end
  end

  // Open-drain: only ever pull low, the external pull-ups supply the high level.
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  assign dout    = dout_q;
  assign busy    = busy_q;
  assign ackErr  = ack_err_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_master.sv
// Directed bench for the I2C master: a cycle-scheduled slave, a bus monitor and a byte scoreboard.
module tb_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rw = 1'b0;
  logic       dataValid = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       busy, ackErr, done;
  logic [3:0] state_o;
  wire        sda, scl;
  logic       slave_sda_low = 1'b0;

  pullup (sda);
  pullup (scl);
  assign sda = slave_sda_low ? 1'b0 : 1'bz;

  master dut (
    .clk      (clk),
    .rst      (rst),
    .rw       (rw),
    .dataValid(dataValid),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .busy     (busy),
    .ackErr   (ackErr),
    .done     (done),
    .sda      (sda),
    .scl      (scl),
    .state_o  (state_o)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic bits_q[$];
  int   rise_q[$];
  int   hi_toggles = 0;
  int   fall_cyc = -1;
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;

  always @(negedge clk) begin
    if (scl === 1'b1 && scl_prev === 1'b0) begin
      bits_q.push_back(sda);
      rise_q.push_back(cyc);
    end
    if (scl === 1'b1 && scl_prev === 1'b1 && sda !== sda_prev) begin
      hi_toggles++;
      if (sda_prev === 1'b1 && sda === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
    end
    scl_prev = scl;
    sda_prev = sda;
  end

  function automatic logic [7:0] get_byte(input int s);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) begin
      if (s + i < bits_q.size()) b = {b[6:0], bits_q[s+i]};
    end
    return b;
  endfunction

  function automatic logic get_bit(input int s);
    if (s < bits_q.size()) return bits_q[s];
    return 1'bx;
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] dout_exp = '0;

  // ---------------- slave model ----------------
  task automatic slave_run(input logic r, input logic ack_a, input logic ack_d,
                           input logic [7:0] rb, input int nbits);
    for (int n = 0; n < nbits; n++) begin
      slave_sda_low = 1'b0;
      if (n == 9 && ack_a) slave_sda_low = 1'b1;
      if (ack_a && r && n >= 10 && n <= 17) slave_sda_low = !rb[3'(17 - n)];
      if (ack_a && !r && n == 18 && ack_d) slave_sda_low = 1'b1;
      repeat (500) @(posedge clk);
      #1;
    end
    slave_sda_low = 1'b0;
  endtask

  // ---------------- transaction driver ----------------
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic ack_a, input logic ack_d, input logic [7:0] rb,
                         input logic hold, input int exp_len, input logic exp_err);
    int   t0;
    int   k;
    int   nbits;
    logic [7:0] e;
    nbits = ack_a ? 20 : 11;
    bits_q.delete();
    rise_q.delete();
    hi_toggles = 0;
    fall_cyc   = -1;
    exp_q.push_back({a, r});
    if (ack_a) exp_q.push_back(r ? rb : d);
    if (r && ack_a) dout_exp = rb;

    @(negedge clk);
    addr = a; rw = r; din = d; dataValid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    check("busy_accept", busy, 1'b1);
    check("ackerr_clear", ackErr, 1'b0);
    if (hold) begin
      addr = 7'h11; din = 8'hFF; rw = !r;
    end else begin
      dataValid = 1'b0;
    end
    k = 0;
    fork
      slave_run(r, ack_a, ack_d, rb, nbits);
      begin
        while (k < exp_len + 2000) begin
          @(posedge clk);
          k++;
          #1;
          if (done) break;
        end
      end
      begin
        if (hold) begin
          repeat (100) @(posedge clk);
          #1;
          dataValid = 1'b0;
        end
      end
    join

    check("done_latency", k, exp_len);
    check("busy_end", busy, 1'b0);
    check("ackerr_end", ackErr, exp_err);
    check("dout", dout, dout_exp);
    check("sda_toggles_scl_high", hi_toggles, 2);
    check("start_fall_delay", fall_cyc - t0, 250);
    check("scl_rises", rise_q.size(), nbits - 1);
    if (rise_q.size() >= 2) check("scl_period", rise_q[1] - rise_q[0], 500);
    e = exp_q.pop_front();
    check("addr_byte", get_byte(0), e);
    check("addr_ack_bit", get_bit(8), !ack_a);
    if (ack_a) begin
      e = exp_q.pop_front();
      check("data_byte", get_byte(9), e);
      check("data_ack_bit", get_bit(17), r ? 1'b1 : !ack_d);
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 1'b0);
    check("state_idle", state_o, 4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2500) @(posedge clk);
    #1;
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_ackerr", ackErr, 1'b0);

    // addr, rw, din, ack_a, ack_d, rd_byte, hold_dv, length, ackErr
    run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 10000, 1'b0);
    run_txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 10000, 1'b0);
    run_txn(7'h23, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 5500,  1'b1);
    run_txn(7'h50, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 10000, 1'b1);
    run_txn(7'h1F, 1'b1, 8'h00, 1'b1, 1'b0, 8'h81, 1'b0, 10000, 1'b0);

    // Reset in the middle of the address byte, while the master holds SDA low.
    @(negedge clk);
    addr = 7'h50; rw = 1'b0; din = 8'hA5; dataValid = 1'b1;
    @(posedge clk);
    #1 dataValid = 1'b0;
    repeat (3010) @(posedge clk);
    #1;
    check("mid_pre_scl", scl, 1'b0);
    check("mid_pre_sda", sda, 1'b0);
    rst = 1'b0;
    #2;
    check("mid_rst_scl", scl, 1'b1);
    check("mid_rst_sda", sda, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    dout_exp = 8'h00;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    run_txn(7'h2B, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 10000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
